truth_table_checker: RTL and testbench

Self-running stimulus/response checker for combinational gate blocks (and/or/nand/xor/mux/decoder style). It generates each input combination in ascending binary order and drives it to the device under test (DUT). After a fixed settle time it samples the DUT's single-bit output and compares it against an expected truth table held in a parameter. It counts mismatches and records the first failing vector, so gate-level blocks can be checked with pass/fail flags instead of by reading waveforms.

---
 rtl/truth_table_checker.sv | 145 ++++++++++++++
 tb/tb_truth_table_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker: steps o_vec through every input combination of a
// combinational DUT, samples i_dut after a settle time and checks it
// against EXP_TABLE, counting mismatches and keeping the first failure.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_start        start request (taken only when idle or done)
//   i_dut          DUT output under check
//   o_vec          stimulus vector to the DUT inputs
//   o_busy         run in progress
//   o_done         run complete (held until next start or reset)
//   o_pass         no mismatches in the completed run
//   o_err_cnt      mismatch count of current/last run
//   o_first_fail   first mismatching vector
//   o_fail_valid   o_first_fail is meaningful
module truth_table_checker #(
   parameter int                      N_IN      = 4,
   parameter int                      SETTLE    = 2,
   parameter logic [(1<<N_IN)-1:0]    EXP_TABLE = 16'h8000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_dut,
   output logic [N_IN-1:0] o_vec,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
   output logic [N_IN:0]   o_err_cnt,
   output logic [N_IN-1:0] o_first_fail,
   output logic            o_fail_valid
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [N_IN-1:0] LAST  = {N_IN{1'b1}};
   localparam logic [SW-1:0]   S_END = SW'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   state_t          r_state, w_state;
   logic [N_IN-1:0] r_vec, w_vec;
   logic [SW-1:0]   r_settle, w_settle;
   logic [N_IN:0]   r_err, w_err;
   logic [N_IN-1:0] r_ff, w_ff;
   logic            r_fv, w_fv;
   logic            r_busy, w_busy;
   logic            r_done, w_done;
   logic            r_pass, w_pass;
   logic            w_miss;
   logic [N_IN:0]   w_err_smp;

   assign w_miss    = (i_dut != EXP_TABLE[r_vec]);
   // count including the vector being sampled now, so o_pass on the
   // final vector reflects its own result
   assign w_err_smp = r_err + {{N_IN{1'b0}}, w_miss};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_vec    <= '0;
         r_settle <= '0;
         r_err    <= '0;
         r_ff     <= '0;
         r_fv     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_vec    <= w_vec;
         r_settle <= w_settle;
         r_err    <= w_err;
         r_ff     <= w_ff;
         r_fv     <= w_fv;
         r_busy   <= w_busy;
         r_done   <= w_done;
         r_pass   <= w_pass;
      end
   end

   always_comb begin
      w_state  = r_state;
      w_vec    = r_vec;
      w_settle = r_settle;
      w_err    = r_err;
      w_ff     = r_ff;
      w_fv     = r_fv;
      w_busy   = r_busy;
      w_done   = r_done;
      w_pass   = r_pass;
      unique case (r_state)
         IDLE, DONE: begin
            if (i_start) begin
               w_state  = DRIVE;
               w_vec    = '0;
               w_settle = '0;
               w_err    = '0;
               w_ff     = '0;
               w_fv     = 1'b0;
               w_busy   = 1'b1;
               w_done   = 1'b0;
               w_pass   = 1'b0;
            end
         end
         DRIVE: begin
            w_settle = r_settle + 1'b1;
            if (r_settle == S_END) begin
               w_state = SAMPLE;
            end
         end
         SAMPLE: begin
            w_err = w_err_smp;
            if (w_miss && !r_fv) begin
               w_ff = r_vec;
               w_fv = 1'b1;
            end
            if (r_vec == LAST) begin
               w_state = DONE;
               w_vec   = '0;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_pass  = (w_err_smp == '0);
            end else begin
               w_state  = DRIVE;
               w_vec    = r_vec + 1'b1;
               w_settle = '0;
            end
         end
         default: w_state = IDLE;
      endcase
   end

   assign o_vec        = r_vec;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_err_cnt    = r_err;
   assign o_first_fail = r_ff;
   assign o_fail_valid = r_fv;

endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed bench for truth_table_checker with
// a 4-input AND table instance and a 2-input XOR table instance.
module tb_truth_table_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance A: defaults (AND4, SETTLE=2)
   logic       a_rst = 1'b0, a_start = 1'b0, a_dut;
   logic [1:0] a_mode = 2'd0;
   logic [3:0] a_vec, a_ff;
   logic [4:0] a_err;
   logic       a_busy, a_done, a_pass, a_fv;

   assign a_dut = (a_mode == 2'd0) ? &a_vec : (a_mode == 2'd2);

   truth_table_checker u_a (
      .clk(clk), .rst(a_rst), .i_start(a_start), .i_dut(a_dut),
      .o_vec(a_vec), .o_busy(a_busy), .o_done(a_done),
      .o_pass(a_pass), .o_err_cnt(a_err), .o_first_fail(a_ff),
      .o_fail_valid(a_fv)
   );

   // instance B: XOR2 table, SETTLE=1
   logic       b_rst = 1'b0, b_start = 1'b0, b_dut, b_xnor = 1'b0;
   logic [1:0] b_vec, b_ff;
   logic [2:0] b_err;
   logic       b_busy, b_done, b_pass, b_fv;

   assign b_dut = b_xnor ? ~^b_vec : ^b_vec;

   truth_table_checker #(
      .N_IN(2), .SETTLE(1), .EXP_TABLE(4'h6)
   ) u_b (
      .clk(clk), .rst(b_rst), .i_start(b_start), .i_dut(b_dut),
      .o_vec(b_vec), .o_busy(b_busy), .o_done(b_done),
      .o_pass(b_pass), .o_err_cnt(b_err), .o_first_fail(b_ff),
      .o_fail_valid(b_fv)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // start a run on A; optional start pulse / reset at cycle index.
   // n = cycles from start edge until done (or until reset edge).
   task automatic run_a(input int pulse_at, input int rst_at,
                        output int n, output int verr);
      int ev;
      n    = 0;
      verr = 0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("a_busy_at_start", a_busy, 1);
      chk("a_done_at_start", a_done, 0);
      while (!a_done && n < 200) begin
         if (n == pulse_at) a_start = 1'b1;
         if (n == rst_at)   a_rst   = 1'b1;
         tick();
         n++;
         a_start = 1'b0;
         if (a_rst) begin
            a_rst = 1'b0;
            break;
         end
         ev = (n < 48) ? n / 3 : 0;
         if (a_vec != 4'(ev)) verr++;
      end
   endtask

   task automatic run_b(output int n);
      n = 0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      while (!b_done && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, "_outs"},
          int'({a_vec, a_busy, a_done, a_pass, a_err, a_ff, a_fv}), 0);
   endtask

   int n, verr;

   initial begin
      // 1: reset with start held
      a_rst = 1'b1; a_start = 1'b1;
      b_rst = 1'b1;
      tick(); tick();
      chk_a_zero("rst");
      a_rst = 1'b0; a_start = 1'b0;
      b_rst = 1'b0;
      tick(); tick();
      chk_a_zero("rst_idle");

      // 2: good AND4
      a_mode = 2'd0;
      run_a(-1, -1, n, verr);
      chk("and_len", n, 48);
      chk("and_vecseq", verr, 0);
      chk("and_pass", a_pass, 1);
      chk("and_err", a_err, 0);
      chk("and_fv", a_fv, 0);
      chk("and_busy", a_busy, 0);
      chk("and_vec0", a_vec, 0);

      // 3: stuck-at-0
      a_mode = 2'd1;
      run_a(-1, -1, n, verr);
      chk("s0_len", n, 48);
      chk("s0_err", a_err, 1);
      chk("s0_ff", a_ff, 15);
      chk("s0_fv", a_fv, 1);
      chk("s0_pass", a_pass, 0);

      // 4: stuck-at-1 then good rerun
      a_mode = 2'd2;
      run_a(-1, -1, n, verr);
      chk("s1_err", a_err, 15);
      chk("s1_ff", a_ff, 0);
      chk("s1_fv", a_fv, 1);
      chk("s1_pass", a_pass, 0);
      tick(); tick();
      chk("s1_done_hold", a_done, 1);
      a_mode = 2'd0;
      run_a(-1, -1, n, verr);
      chk("rerun_err", a_err, 0);
      chk("rerun_fv", a_fv, 0);
      chk("rerun_pass", a_pass, 1);

      // 5: start while busy, then reset mid-run, then clean run
      run_a(10, -1, n, verr);
      chk("busy_start_len", n, 48);
      chk("busy_start_vecseq", verr, 0);
      chk("busy_start_pass", a_pass, 1);
      a_mode = 2'd2;
      run_a(-1, 20, n, verr);
      chk("midrst_cyc", n, 21);
      chk_a_zero("midrst");
      tick(); tick();
      chk("midrst_stay_idle", a_busy, 0);
      a_mode = 2'd0;
      run_a(-1, -1, n, verr);
      chk("post_rst_len", n, 48);
      chk("post_rst_vecseq", verr, 0);
      chk("post_rst_pass", a_pass, 1);

      // 6: XOR2 table
      b_xnor = 1'b0;
      run_b(n);
      chk("xor_len", n, 8);
      chk("xor_pass", b_pass, 1);
      chk("xor_err", b_err, 0);
      b_xnor = 1'b1;
      run_b(n);
      chk("xnor_len", n, 8);
      chk("xnor_err", b_err, 4);
      chk("xnor_ff", b_ff, 0);
      chk("xnor_fv", b_fv, 1);
      chk("xnor_pass", b_pass, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
